// File: rtl/adder_sequencer.sv
// ============================================================================
// Module  : adder_sequencer
// Brief   : Debounced two-key operand-entry FSM that captures A and B from the
//           slide switches and presents A+B to the hex/7-segment decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key_next,
    input  logic       key_clear,
    output logic [3:0] hex,
    output logic [1:0] button,
    output logic       carry
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               C_NEXT     = 0;
    localparam int               C_CLEAR    = 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTER_A  = 2'd1,
        S_ENTER_B  = 2'd2,
        S_SHOW_SUM = 2'd3
    } state_t;

    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {key_clear, key_next};

    // Press is the cycle the debounced level falls; release flips are ignored.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             r_meta;
        logic             r_sync;
        logic             r_deb;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_meta <= 1'b1;
                r_sync <= 1'b1;
                r_deb  <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_key_raw[k];
                r_sync <= r_meta;
                if (r_sync != r_deb) begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_deb <= r_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[k] = (r_sync != r_deb) && (r_cnt == C_CNT_LAST) && !r_sync;
    end

    state_t     r_state;
    logic [3:0] r_a;
    logic [4:0] r_sum;
    logic [4:0] w_sum_new;

    // Operand B only ever feeds the sum, so it is captured directly into r_sum.
    assign w_sum_new = {1'b0, r_a} + {1'b0, sw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_sum   <= '0;
            hex     <= '0;
            button  <= 2'b11;
            carry   <= 1'b0;
        end else if (w_press[C_CLEAR]) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_sum   <= '0;
            hex     <= '0;
            button  <= 2'b11;
            carry   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    hex    <= '0;
                    button <= 2'b11;
                    carry  <= 1'b0;
                    if (w_press[C_NEXT]) begin
                        r_state <= S_ENTER_A;
                        hex     <= sw;
                        button  <= 2'b01;
                    end
                end
                S_ENTER_A: begin
                    hex    <= sw;
                    button <= 2'b01;
                    carry  <= 1'b0;
                    if (w_press[C_NEXT]) begin
                        r_state <= S_ENTER_B;
                        r_a     <= sw;
                        button  <= 2'b10;
                    end
                end
                S_ENTER_B: begin
                    hex    <= sw;
                    button <= 2'b10;
                    carry  <= 1'b0;
                    if (w_press[C_NEXT]) begin
                        r_state <= S_SHOW_SUM;
                        r_sum   <= w_sum_new;
                        hex     <= w_sum_new[3:0];
                        carry   <= w_sum_new[4];
                        button  <= 2'b00;
                    end
                end
                S_SHOW_SUM: begin
                    hex    <= r_sum[3:0];
                    button <= 2'b00;
                    carry  <= r_sum[4];
                    if (w_press[C_NEXT]) begin
                        r_state <= S_ENTER_A;
                        hex     <= sw;
                        button  <= 2'b01;
                        carry   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    hex     <= '0;
                    button  <= 2'b11;
                    carry   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
